// File: rtl/engine_divide_signed_ctrl.sv
// Signed/unsigned front/back-end for an external unsigned multi-cycle divider.
// Optional ENGINE_DIVIDE_SHORTCUT_EN resolves |d|>|n| and |d|==1 without the divider.
module engine_divide_signed_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clock_areset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_signed,
    input  logic [WIDTH-1:0] req_numerator,
    input  logic [WIDTH-1:0] req_denominator,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_quotient,
    output logic [WIDTH-1:0] rsp_remainder,
    output logic             rsp_div_zero,
    output logic             rsp_overflow,
    output logic             div_go,
    output logic [WIDTH-1:0] div_numerator,
    output logic [WIDTH-1:0] div_denominator,
    input  logic             div_busy,
    input  logic             div_result_valid,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);
    localparam logic [WIDTH-1:0] MIN  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ISSUE, S_WAIT, S_FIXUP, S_RESP} state_t;
    state_t state, state_nxt;

    logic             sgn_r;
    logic [WIDTH-1:0] num_r, den_r, uq_r, ur_r;

    // Operand registers stay stable from accept to response, so signs/magnitudes stay combinational.
    logic             neg_n, neg_d, is_zero, is_ovf, bypass;
    logic [WIDTH-1:0] mag_n, mag_d, byp_uq, byp_ur, fix_uq, fix_ur, fix_q, fix_r;

    assign neg_n   = sgn_r & num_r[WIDTH-1];
    assign neg_d   = sgn_r & den_r[WIDTH-1];
    assign mag_n   = neg_n ? -num_r : num_r;
    assign mag_d   = neg_d ? -den_r : den_r;
    assign is_zero = (den_r == '0);
    assign is_ovf  = sgn_r && (num_r == MIN) && (den_r == ONES);

`ifdef ENGINE_DIVIDE_SHORTCUT_EN
    always_comb begin
        bypass = 1'b0;
        byp_uq = '0;
        byp_ur = '0;
        if (mag_d > mag_n) begin
            bypass = 1'b1;
            byp_ur = mag_n;
        end else if (mag_d == WIDTH'(1)) begin
            bypass = 1'b1;
            byp_uq = mag_n;
        end
    end
`else
    assign bypass = 1'b0;
    assign byp_uq = '0;
    assign byp_ur = '0;
`endif

    // Sign fixup is shared by the PREP bypass path and the FIXUP state.
    assign fix_uq = (state == S_PREP) ? byp_uq : uq_r;
    assign fix_ur = (state == S_PREP) ? byp_ur : ur_r;
    assign fix_q  = (neg_n ^ neg_d) ? -fix_uq : fix_uq;
    assign fix_r  = neg_n ? -fix_ur : fix_ur;

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) state <= S_IDLE;
        else                 state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid) state_nxt = S_PREP;
            S_PREP:  state_nxt = (is_zero || is_ovf || bypass) ? S_RESP : S_ISSUE;
            S_ISSUE: if (!div_busy) state_nxt = S_WAIT;
            S_WAIT:  if (div_result_valid) state_nxt = S_FIXUP;
            S_FIXUP: state_nxt = S_RESP;
            S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == S_IDLE);
        rsp_valid = (state == S_RESP);
        div_go    = (state == S_ISSUE) && !div_busy;
    end

    always_ff @(posedge clock or negedge clock_areset_n) begin
        if (!clock_areset_n) begin
            sgn_r           <= 1'b0;
            num_r           <= '0;
            den_r           <= '0;
            uq_r            <= '0;
            ur_r            <= '0;
            div_numerator   <= '0;
            div_denominator <= '0;
            rsp_quotient    <= '0;
            rsp_remainder   <= '0;
            rsp_div_zero    <= 1'b0;
            rsp_overflow    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) begin
                    sgn_r <= req_signed;
                    num_r <= req_numerator;
                    den_r <= req_denominator;
                end
                S_PREP: begin
                    div_numerator   <= mag_n;
                    div_denominator <= mag_d;
                    rsp_div_zero    <= 1'b0;
                    rsp_overflow    <= 1'b0;
                    if (is_zero) begin
                        rsp_quotient  <= ONES;
                        rsp_remainder <= num_r;
                        rsp_div_zero  <= 1'b1;
                    end else if (is_ovf) begin
                        rsp_quotient  <= MIN;
                        rsp_remainder <= '0;
                        rsp_overflow  <= 1'b1;
                    end else if (bypass) begin
                        rsp_quotient  <= fix_q;
                        rsp_remainder <= fix_r;
                    end
                end
                S_WAIT: if (div_result_valid) begin
                    uq_r <= div_quotient;
                    ur_r <= div_remainder;
                end
                S_FIXUP: begin
                    rsp_quotient  <= fix_q;
                    rsp_remainder <= fix_r;
                    rsp_div_zero  <= 1'b0;
                    rsp_overflow  <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_engine_divide_signed_ctrl.sv
// Randomized bench for engine_divide_signed_ctrl with a behavioural divider and reference model.
module tb_engine_divide_signed_ctrl;
    localparam int W = 32;
    localparam logic [W-1:0] MIN  = 32'h8000_0000;
    localparam logic [W-1:0] ONES = 32'hFFFF_FFFF;

    logic         clock = 0, clock_areset_n = 0;
    logic         req_valid = 0, req_signed = 0, rsp_ready = 0;
    logic [W-1:0] req_numerator = 0, req_denominator = 0;
    logic         req_ready, rsp_valid, rsp_div_zero, rsp_overflow, div_go;
    logic [W-1:0] rsp_quotient, rsp_remainder, div_numerator, div_denominator;
    logic         div_busy, div_result_valid;
    logic [W-1:0] div_quotient, div_remainder;

    int n_chk = 0, n_fail = 0, go_total = 0, dcnt = 0;

    always #5 clock = ~clock;

    engine_divide_signed_ctrl #(.WIDTH(W)) dut (
        .clock(clock), .clock_areset_n(clock_areset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
        .req_numerator(req_numerator), .req_denominator(req_denominator),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
        .rsp_div_zero(rsp_div_zero), .rsp_overflow(rsp_overflow),
        .div_go(div_go), .div_numerator(div_numerator), .div_denominator(div_denominator),
        .div_busy(div_busy), .div_result_valid(div_result_valid),
        .div_quotient(div_quotient), .div_remainder(div_remainder)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Unsigned divider: result pulses WIDTH+1 cycles after go; not reset by the DUT's reset.
    always @(posedge clock) begin
        if (div_go) begin
            dcnt          <= W + 1;
            div_quotient  <= (div_denominator == 0) ? ONES : div_numerator / div_denominator;
            div_remainder <= (div_denominator == 0) ? div_numerator : div_numerator % div_denominator;
        end else if (dcnt > 0) dcnt <= dcnt - 1;
    end
    assign div_busy         = (dcnt != 0);
    assign div_result_valid = (dcnt == 1);

    always @(negedge clock) if (div_go) begin
        go_total++;
        check("go_while_idle", {31'b0, div_busy}, 0);
    end

    function automatic logic [W-1:0] mag(input logic s, input logic [W-1:0] x);
        return (s && x[W-1]) ? -x : x;
    endfunction

    task automatic run_req(input logic s, input logic [W-1:0] n, input logic [W-1:0] d,
                           input int hold, input bit exact_lat);
        logic [W-1:0] eq, er;
        logic edz, eov;
        bit   skip;
        int   elat, t, go0;
        edz = 0; eov = 0; skip = 0;
        if (d == 0) begin
            eq = ONES; er = n; edz = 1; skip = 1;
        end else if (s && n == MIN && d == ONES) begin
            eq = MIN; er = 0; eov = 1; skip = 1;
        end else if (s) begin
            eq = $signed(n) / $signed(d);
            er = $signed(n) % $signed(d);
        end else begin
            eq = n / d;
            er = n % d;
        end
`ifdef ENGINE_DIVIDE_SHORTCUT_EN
        if (!skip && (mag(s, d) > mag(s, n) || mag(s, d) == 1)) skip = 1;
`endif
        elat = skip ? 2 : W + 5;

        t = 0;
        while (!req_ready && t < 200) begin @(posedge clock); #1; t++; end
        check("req_ready_idle", {31'b0, req_ready}, 1);
        req_valid = 1; req_signed = s; req_numerator = n; req_denominator = d;
        go0 = go_total;
        @(posedge clock); #1;
        req_valid = 0; req_numerator = $urandom; req_denominator = $urandom;
        t = 0;
        while (!rsp_valid && t < 300) begin @(posedge clock); #1; t++; end
        check("rsp_valid", {31'b0, rsp_valid}, 1);
        if (exact_lat) check("latency", t + 1, elat);
        else           check("latency_waited", {31'b0, (t + 1 > W + 5)}, 1);
        check("quotient", rsp_quotient, eq);
        check("remainder", rsp_remainder, er);
        check("div_zero", {31'b0, rsp_div_zero}, {31'b0, edz});
        check("overflow", {31'b0, rsp_overflow}, {31'b0, eov});
        check("go_pulses", go_total - go0, skip ? 0 : 1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check("hold_valid", {31'b0, rsp_valid}, 1);
            check("hold_q", rsp_quotient, eq);
            check("hold_r", rsp_remainder, er);
            check("hold_req_ready", {31'b0, req_ready}, 0);
        end
        rsp_ready = 1;
        @(posedge clock); #1;
        rsp_ready = 0;
        check("rsp_dropped", {31'b0, rsp_valid}, 0);
        check("req_ready_after", {31'b0, req_ready}, 1);
    endtask

    initial begin
        logic s;
        logic [W-1:0] n, d;
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_div_go", {31'b0, div_go}, 0);
        check("rst_q", rsp_quotient, 0);
        check("rst_flags", {30'b0, rsp_div_zero, rsp_overflow}, 0);
        @(posedge clock); #1; clock_areset_n = 1;
        @(posedge clock); #1;

        run_req(1, 32'hFFFF_FFF9, 32'h2, 0, 1);
        run_req(0, 100, 7, 0, 1);
        run_req(0, 5, 0, 0, 1);
        run_req(1, 5, 0, 0, 1);
        run_req(1, MIN, ONES, 0, 1);
        run_req(0, MIN, ONES, 0, 1);
        run_req(1, 32'hFFFF_FF9C, 7, 10, 1);

        // Abort mid-divide: divider keeps running, so the next request must wait in ISSUE.
        req_valid = 1; req_signed = 0; req_numerator = 1000; req_denominator = 3;
        @(posedge clock); #1; req_valid = 0;
        repeat (10) @(posedge clock);
        #1; clock_areset_n = 0; #1;
        check("arst_req_ready", {31'b0, req_ready}, 1);
        check("arst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("arst_div_go", {31'b0, div_go}, 0);
        check("arst_div_num", div_numerator, 0);
        check("arst_div_den", div_denominator, 0);
        check("arst_q", rsp_quotient, 0);
        check("arst_busy_model", {31'b0, div_busy}, 1);
        @(posedge clock); #1; clock_areset_n = 1;
        run_req(1, 32'hFFFF_FC18, 7, 0, 0);

        for (int k = 0; k < 40; k++) begin
            s = 1'($urandom_range(0, 1));
            n = $urandom; d = $urandom;
            case ($urandom_range(0, 5))
                0: ;
                1: d = 0;
                2: begin n = MIN; d = ONES; end
                3: d = 32'($urandom_range(0, 8)) - 4;
                4: begin n = 32'($urandom_range(0, 50)) - 25; d = 32'($urandom_range(1, 30)); end
                default: d = ($urandom_range(0, 1) != 0) ? 32'h1 : ONES;
            endcase
            run_req(s, n, d, $urandom_range(0, 2), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
